// File: rtl/regbus_pkg.sv
// Shared definitions for the register bus initiator and the regfiles it drives.
package regbus_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 8;

    // Host command opcodes
    typedef enum logic [1:0] {
        OP_WRITE    = 2'd0,
        OP_READ     = 2'd1,
        OP_BURST_WR = 2'd2,
        OP_POLL     = 2'd3
    } op_e;

    // Initiator sequencing states; IDLE must encode to zero
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR        = 3'd1,
        RD        = 3'd2,
        BURST     = 3'd3,
        BWR       = 3'd4,
        POLL_RD   = 3'd5,
        POLL_WAIT = 3'd6,
        RESP      = 3'd7
    } state_e;

endpackage

// File: rtl/regbus_master.sv
// Register bus initiator: turns host commands (write, read, burst write,
// poll-until-match) into single-cycle wr_en/rd_en accesses and returns one
// response per command. Every output is a register.
module regbus_master #(
    parameter int ADDR_W   = regbus_pkg::ADDR_W,
    parameter int DATA_W   = regbus_pkg::DATA_W,
    parameter int LEN_W    = regbus_pkg::LEN_W,
    parameter int POLL_MAX = 1024,
    parameter int POLL_GAP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [DATA_W-1:0] cmd_mask,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data
);
    import regbus_pkg::*;

    localparam int ATT_W = $clog2(POLL_MAX + 1);
    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    state_e            state_reg, state_next;
    logic [ADDR_W-1:0] base_reg, base_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic [DATA_W-1:0] mask_reg, mask_next;
    logic [LEN_W-1:0]  len_reg, len_next;
    logic [LEN_W-1:0]  beat_reg, beat_next;
    logic [ATT_W-1:0]  att_reg, att_next;
    logic [GAP_W-1:0]  gap_reg, gap_next;

    logic              cmd_ready_reg, cmd_ready_next;
    logic              wdata_ready_reg, wdata_ready_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;
    logic              rsp_err_reg, rsp_err_next;
    logic              wr_en_reg, wr_en_next;
    logic              rd_en_reg, rd_en_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] write_data_reg, write_data_next;

    logic              poll_match;

    assign cmd_ready   = cmd_ready_reg;
    assign wdata_ready = wdata_ready_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_data    = rsp_data_reg;
    assign rsp_err     = rsp_err_reg;
    assign wr_en       = wr_en_reg;
    assign rd_en       = rd_en_reg;
    assign addr        = addr_reg;
    assign write_data  = write_data_reg;

    // Only bits selected by the mask take part in the poll comparison
    assign poll_match = ((read_data ^ data_reg) & mask_reg) == '0;

    // State, latched command and registered outputs; reset clears everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            base_reg        <= '0;
            data_reg        <= '0;
            mask_reg        <= '0;
            len_reg         <= '0;
            beat_reg        <= '0;
            att_reg         <= '0;
            gap_reg         <= '0;
            cmd_ready_reg   <= 1'b0;
            wdata_ready_reg <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_data_reg    <= '0;
            rsp_err_reg     <= 1'b0;
            wr_en_reg       <= 1'b0;
            rd_en_reg       <= 1'b0;
            addr_reg        <= '0;
            write_data_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            base_reg        <= base_next;
            data_reg        <= data_next;
            mask_reg        <= mask_next;
            len_reg         <= len_next;
            beat_reg        <= beat_next;
            att_reg         <= att_next;
            gap_reg         <= gap_next;
            cmd_ready_reg   <= cmd_ready_next;
            wdata_ready_reg <= wdata_ready_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_data_reg    <= rsp_data_next;
            rsp_err_reg     <= rsp_err_next;
            wr_en_reg       <= wr_en_next;
            rd_en_reg       <= rd_en_next;
            addr_reg        <= addr_next;
            write_data_reg  <= write_data_next;
        end
    end

    // Next state and next output values; strobes default low, everything else holds
    always_comb begin
        state_next      = state_reg;
        base_next       = base_reg;
        data_next       = data_reg;
        mask_next       = mask_reg;
        len_next        = len_reg;
        beat_next       = beat_reg;
        att_next        = att_reg;
        gap_next        = gap_reg;
        rsp_valid_next  = rsp_valid_reg;
        rsp_data_next   = rsp_data_reg;
        rsp_err_next    = rsp_err_reg;
        wr_en_next      = 1'b0;
        rd_en_next      = 1'b0;
        addr_next       = addr_reg;
        write_data_next = write_data_reg;

        case (state_reg)
            IDLE: begin
                if (cmd_valid && cmd_ready_reg) begin
                    base_next = cmd_addr;
                    data_next = cmd_data;
                    mask_next = cmd_mask;
                    len_next  = cmd_len;
                    beat_next = '0;
                    case (op_e'(cmd_op))
                        OP_WRITE: begin
                            state_next      = WR;
                            wr_en_next      = 1'b1;
                            addr_next       = cmd_addr;
                            write_data_next = cmd_data;
                        end
                        OP_READ: begin
                            state_next = RD;
                            rd_en_next = 1'b1;
                            addr_next  = cmd_addr;
                        end
                        OP_BURST_WR: begin
                            if (cmd_len == '0) begin
                                // Empty burst answers immediately with a zero count
                                state_next     = RESP;
                                rsp_valid_next = 1'b1;
                                rsp_data_next  = '0;
                                rsp_err_next   = 1'b0;
                            end else begin
                                state_next = BURST;
                            end
                        end
                        OP_POLL: begin
                            state_next = POLL_RD;
                            rd_en_next = 1'b1;
                            addr_next  = cmd_addr;
                            att_next   = ATT_W'(1);
                        end
                        default: ;
                    endcase
                end
            end
            WR: begin
                state_next     = RESP;
                rsp_valid_next = 1'b1;
                rsp_data_next  = data_reg;
                rsp_err_next   = 1'b0;
            end
            RD: begin
                state_next     = RESP;
                rsp_valid_next = 1'b1;
                rsp_data_next  = read_data;
                rsp_err_next   = 1'b0;
            end
            BURST: begin
                if (wdata_valid && wdata_ready_reg) begin
                    state_next      = BWR;
                    wr_en_next      = 1'b1;
                    addr_next       = base_reg + ADDR_W'(beat_reg);
                    write_data_next = wdata;
                    beat_next       = beat_reg + LEN_W'(1);
                end
            end
            BWR: begin
                if (beat_reg == len_reg) begin
                    state_next     = RESP;
                    rsp_valid_next = 1'b1;
                    rsp_data_next  = DATA_W'(beat_reg);
                    rsp_err_next   = 1'b0;
                end else begin
                    state_next = BURST;
                end
            end
            POLL_RD: begin
                if (poll_match || att_reg == ATT_W'(POLL_MAX)) begin
                    state_next     = RESP;
                    rsp_valid_next = 1'b1;
                    rsp_data_next  = read_data;
                    rsp_err_next   = !poll_match;
                end else begin
                    state_next = POLL_WAIT;
                    gap_next   = GAP_W'(POLL_GAP - 1);
                end
            end
            POLL_WAIT: begin
                // Issue the next read so it lands exactly POLL_GAP idle cycles later
                if (gap_reg == '0) begin
                    state_next = POLL_RD;
                    rd_en_next = 1'b1;
                    att_next   = att_reg + ATT_W'(1);
                end else begin
                    gap_next = gap_reg - GAP_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next     = IDLE;
                    rsp_valid_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase

        // Handshake readies are registered decodes of the upcoming state
        cmd_ready_next   = (state_next == IDLE);
        wdata_ready_next = (state_next == BURST);
    end

endmodule

// File: tb/tb_regbus_master.sv
// Randomized bench for regbus_master: a small regfile environment answers the
// bus, and a command-level model predicts bus accesses and responses.
module tb_regbus_master;
    import regbus_pkg::*;

    localparam int AW   = 14;
    localparam int DW   = 16;
    localparam int LW   = 8;
    localparam int PMAX = 8;
    localparam int PGAP = 4;
    localparam logic [AW-1:0] STATUS_ADDR = 14'h111;
    localparam logic [AW-1:0] BIAS_ADDR   = 14'h115;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data, cmd_mask;
    logic [LW-1:0] cmd_len;
    logic          wdata_valid, wdata_ready;
    logic [DW-1:0] wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          wr_en, rd_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] write_data, read_data;

    always #5 clk = ~clk;

    regbus_master #(
        .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .POLL_MAX(PMAX), .POLL_GAP(PGAP)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .write_data(write_data),
        .read_data(read_data)
    );

    // ---------------- regfile environment ----------------
    bit [DW-1:0] mem [0:(1<<AW)-1];
    bit          wrote_bias = 1'b0;
    int          status_reads = 0;
    int          cyc = 0;
    int          both_cnt = 0;

    typedef struct {
        bit            is_wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            c;
    } ev_t;
    ev_t obs_q[$];

    // Status register reads 0 for its first three reads, then 2; use_bias resets to 1
    assign read_data = (addr == STATUS_ADDR) ? ((status_reads >= 3) ? 16'h0002 : 16'h0000) :
                       (addr == BIAS_ADDR && !wrote_bias) ? 16'h0001 : mem[addr];

    // Log every bus access with its cycle index and apply writes
    always @(posedge clk) begin
        if (wr_en) begin
            obs_q.push_back('{1'b1, addr, write_data, cyc});
            mem[addr] <= write_data;
            if (addr == BIAS_ADDR) wrote_bias <= 1'b1;
        end
        if (rd_en) begin
            obs_q.push_back('{1'b0, addr, read_data, cyc});
            if (addr == STATUS_ADDR) status_reads <= status_reads + 1;
        end
        if (wr_en && rd_en) both_cnt <= both_cnt + 1;
        cyc <= cyc + 1;
    end

    // ---------------- reference model state and checking ----------------
    bit [DW-1:0] ref_mem [0:(1<<AW)-1];
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full command: predict, drive, collect response, compare bus trace
    task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW-1:0] m, input logic [LW-1:0] len, input int hold,
                           input bit seq_beats);
        ev_t           exp_q[$];
        logic [DW-1:0] beats[$];
        logic [DW-1:0] exp_data, v;
        logic          exp_err;
        bit            matched;
        int            base, st0, t_acc, t_rsp, wait_n, n_obs;

        base     = obs_q.size();
        st0      = status_reads;
        exp_data = '0;
        exp_err  = 1'b0;
        case (op)
            2'd0: begin
                exp_q.push_back('{1'b1, a, d, 0});
                ref_mem[a] = d;
                exp_data   = d;
            end
            2'd1: begin
                exp_q.push_back('{1'b0, a, ref_mem[a], 0});
                exp_data = ref_mem[a];
            end
            2'd2: begin
                for (int i = 0; i < int'(len); i++) begin
                    beats.push_back(seq_beats ? DW'(i + 1) : DW'($urandom));
                    exp_q.push_back('{1'b1, AW'(int'(a) + i), beats[i], 0});
                    ref_mem[AW'(int'(a) + i)] = beats[i];
                end
                exp_data = DW'(len);
            end
            default: begin
                matched = 1'b0;
                for (int k = 1; k <= PMAX && !matched; k++) begin
                    v = (a == STATUS_ADDR) ? ((st0 + k - 1 >= 3) ? 16'h0002 : 16'h0000) : ref_mem[a];
                    exp_q.push_back('{1'b0, a, v, 0});
                    exp_data = v;
                    matched  = ((v ^ d) & m) == '0;
                end
                exp_err = !matched;
            end
        endcase

        // Present the command and wait for acceptance
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m; cmd_len = len;
        wait_n = 0;
        while (!cmd_ready && wait_n < 50) begin step(); wait_n++; end
        check("cmd_accept", cmd_ready, 1);
        t_acc = cyc;
        step();
        // Junk command held while busy must be ignored
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op = 2'($urandom); cmd_addr = AW'($urandom); cmd_data = DW'($urandom); cmd_len = 8'd3;

        if (op == 2'd2) begin
            for (int i = 0; i < int'(len); i++) begin
                repeat ($urandom_range(0, 3)) step();
                wdata_valid = 1'b1;
                wdata = beats[i];
                wait_n = 0;
                while (!wdata_ready && wait_n < 50) begin step(); wait_n++; end
                check("beat_ready", wdata_ready, 1);
                step();
                wdata_valid = 1'b0;
                wdata = DW'($urandom);
            end
        end

        wait_n = 0;
        while (!rsp_valid && wait_n < 300) begin step(); wait_n++; end
        t_rsp = cyc;
        cmd_valid = 1'b0;
        check("rsp_valid", rsp_valid, 1);
        if (op == 2'd0 || op == 2'd1) check("rsp_latency", t_rsp - t_acc, 2);
        if (op == 2'd2 && len == 0)  check("empty_burst_latency", t_rsp - t_acc, 1);

        for (int h = 0; h < hold; h++) begin
            check("hold_data", rsp_data, exp_data);
            check("hold_err", rsp_err, exp_err);
            step();
            check("hold_valid", rsp_valid, 1);
        end
        check("rsp_data", rsp_data, exp_data);
        check("rsp_err", rsp_err, exp_err);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("rsp_drop", rsp_valid, 0);
        check("ready_after_rsp", cmd_ready, 1);

        // Compare the recorded bus accesses with the prediction
        n_obs = obs_q.size() - base;
        check("access_count", n_obs, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n_obs; i++) begin
            check("access_kind", obs_q[base + i].is_wr, exp_q[i].is_wr);
            check("access_addr", obs_q[base + i].a, exp_q[i].a);
            check("access_data", obs_q[base + i].d, exp_q[i].d);
            if (i > 0 && op == 2'd3)
                check("poll_spacing", obs_q[base + i].c - obs_q[base + i - 1].c, PGAP + 1);
            if (i > 0 && op == 2'd2)
                check("burst_spacing", (obs_q[base + i].c - obs_q[base + i - 1].c) >= 2, 1);
        end
        if ((op == 2'd0 || op == 2'd1) && n_obs > 0)
            check("strobe_latency", obs_q[base].c - t_acc, 1);

        $display("txn op=%0d addr=%h data=%h mask=%h len=%0d -> rsp_data=%h rsp_err=%0d accesses=%0d",
                 op, a, d, m, len, rsp_data, rsp_err, n_obs);
    endtask

    // Burst interrupted by reset after two beats, then a held response
    task automatic reset_mid_burst();
        int base, r_cyc, wait_n;
        base = obs_q.size();
        cmd_valid = 1'b1; cmd_op = OP_BURST_WR; cmd_addr = 14'h101; cmd_len = 8'd5;
        wait_n = 0;
        while (!cmd_ready && wait_n < 50) begin step(); wait_n++; end
        check("rb_accept", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wdata_valid = 1'b1;
            wdata = DW'(16'h0011 * (i + 1));
            wait_n = 0;
            while (!wdata_ready && wait_n < 50) begin step(); wait_n++; end
            step();
            wdata_valid = 1'b0;
        end
        wait_n = 0;
        while (obs_q.size() - base < 2 && wait_n < 50) begin step(); wait_n++; end
        check("rb_two_beats", obs_q.size() - base, 2);
        ref_mem[14'h101] = 16'h0011;
        ref_mem[14'h102] = 16'h0022;

        rst = 1'b1;
        wdata_valid = 1'b1;
        wdata = 16'h0033;
        r_cyc = cyc;
        repeat (2) begin
            step();
            check("rb_rsp_in_reset", rsp_valid, 0);
            check("rb_ready_in_reset", wdata_ready, 0);
        end
        rst = 1'b0;
        wdata_valid = 1'b0;
        step();
        check("rb_ready_after_reset", cmd_ready, 1);
        repeat (5) begin
            step();
            check("rb_no_rsp", rsp_valid, 0);
        end
        check("rb_no_strobes", obs_q.size() - base, 2);
        if (obs_q.size() - base >= 2)
            check("rb_last_strobe_before_reset", obs_q[obs_q.size() - 1].c <= r_cyc, 1);
        $display("txn reset mid-burst: accesses=%0d rsp_valid=%0d", obs_q.size() - base, rsp_valid);

        run_cmd(OP_READ, 14'h102, 16'h0, 16'h0, 8'd0, 10, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] ra;
        logic [DW-1:0] rd, rm;
        logic [1:0]    rop;

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0; cmd_mask = '0; cmd_len = '0;
        wdata_valid = 1'b0; wdata = '0; rsp_ready = 1'b0;
        ref_mem[BIAS_ADDR] = 16'h0001;

        repeat (3) step();
        check("reset_cmd_ready", cmd_ready, 0);
        check("reset_wdata_ready", wdata_ready, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_wr_en", wr_en, 0);
        check("reset_rd_en", rd_en, 0);
        check("reset_addr", addr, 0);
        check("reset_write_data", write_data, 0);
        rst = 1'b0;
        step();
        check("ready_after_reset", cmd_ready, 1);

        run_cmd(OP_READ,     BIAS_ADDR,   16'h0000, 16'h0000, 8'd0, 0, 1'b0);
        run_cmd(OP_WRITE,    14'h101,     16'hABCD, 16'h0000, 8'd0, 2, 1'b0);
        run_cmd(OP_READ,     14'h101,     16'h0000, 16'h0000, 8'd0, 0, 1'b0);
        run_cmd(OP_BURST_WR, 14'h101,     16'h0000, 16'h0000, 8'd5, 1, 1'b1);
        run_cmd(OP_POLL,     STATUS_ADDR, 16'h0002, 16'h000F, 8'd0, 0, 1'b0);
        run_cmd(OP_POLL,     14'h120,     16'h0001, 16'h0001, 8'd0, 0, 1'b0);
        run_cmd(OP_POLL,     14'h120,     16'h5555, 16'h0000, 8'd0, 0, 1'b0);
        run_cmd(OP_BURST_WR, 14'h3FFE,    16'h0000, 16'h0000, 8'd4, 0, 1'b0);
        run_cmd(OP_BURST_WR, 14'h200,     16'h0000, 16'h0000, 8'd0, 1, 1'b0);
        run_cmd(OP_READ,     14'h0001,    16'h0000, 16'h0000, 8'd0, 0, 1'b0);

        reset_mid_burst();

        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom);
            ra  = AW'($urandom_range(14'h200, 14'h3FFF));
            rd  = DW'($urandom);
            rm  = ($urandom_range(0, 3) == 0) ? 16'h0000 : DW'($urandom);
            if (rop == 2'd3 && $urandom_range(0, 1) == 1) rd = ref_mem[ra] ^ (DW'($urandom) & ~rm);
            run_cmd(rop, ra, rd, rm, LW'($urandom_range(0, 6)), $urandom_range(0, 3), 1'b0);
        end

        check("no_simultaneous_strobes", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
